pwm_reg_scheduler: RTL and testbench

PWM_REG_SCHEDULER -- requirements
Module: pwm_reg_scheduler

---
 rtl/pwm_reg_scheduler_pkg.sv | 27 ++
 rtl/pwm_reg_scheduler_rr_arbiter2.sv | 43 ++++
 rtl/pwm_reg_scheduler.sv | 128 ++++++++++++
 tb/tb_pwm_reg_scheduler.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_reg_scheduler_pkg.sv
// Shared constants and types for the PWM register scheduler.
package pwm_reg_scheduler_pkg;

    localparam int unsigned NUM_REGS_DEF = 5;
    localparam int unsigned PERIOD_W_DEF = 8;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned DATA_W       = 8;

    localparam logic [ADDR_W-1:0] ADDR_OUT_EN_LO = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT_EN_HI = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN_LO = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN_HI = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

    // Requester identity; bit position matches the req/gnt vector index.
    typedef enum logic {
        ReqSpi = 1'b0,
        ReqLoc = 1'b1
    } req_e;

    // True when the address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned num_regs);
        return {25'd0, addr} < num_regs;
    endfunction

endpackage

// File: rtl/pwm_reg_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational, pointer registered.
module rr_arbiter2
    import pwm_reg_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_e ptr_q, ptr_d;

    // Grant a lone requester directly; on contention the pointer decides.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == ReqSpi) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // After any grant, favour the other requester; idle cycles keep the pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt[0]) begin
            ptr_d = ReqLoc;
        end else if (gnt[1]) begin
            ptr_d = ReqSpi;
        end
    end

    // Pointer state, reset to favour SPI.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ReqSpi;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pwm_reg_scheduler.sv
// Register write scheduler for a PWM block: arbitrates SPI and local writers,
// holds the enable registers and a double-buffered duty committed on period wrap.
module pwm_reg_scheduler
    import pwm_reg_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_wr_valid,
    input  logic [ADDR_W-1:0]   spi_wr_addr,
    input  logic [DATA_W-1:0]   spi_wr_data,
    output logic                spi_wr_ready,
    input  logic                loc_wr_valid,
    input  logic [ADDR_W-1:0]   loc_wr_addr,
    input  logic [DATA_W-1:0]   loc_wr_data,
    output logic                loc_wr_ready,
    output logic [DATA_W-1:0]   out_en_lo,
    output logic [DATA_W-1:0]   out_en_hi,
    output logic [DATA_W-1:0]   pwm_en_lo,
    output logic [DATA_W-1:0]   pwm_en_hi,
    output logic [DATA_W-1:0]   duty,
    output logic [PERIOD_W-1:0] pwm_cnt,
    output logic                period_start,
    output logic                commit_pending,
    output logic                err_addr
);

    logic [1:0]        req, gnt;
    logic              wr_en, in_range, duty_wr, wrap;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0]   out_en_lo_q, out_en_hi_q, pwm_en_lo_q, pwm_en_hi_q;
    logic [DATA_W-1:0]   shadow_q, shadow_d, duty_q, duty_d;
    logic                pend_q, pend_d, err_q, err_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    // Requests are masked during reset so nothing is granted or dropped half-way.
    assign req = {loc_wr_valid, spi_wr_valid} & {2{~rst}};

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign spi_wr_ready = gnt[ReqSpi];
    assign loc_wr_ready = gnt[ReqLoc];

    // Select the granted requester's address and data.
    always_comb begin
        wr_en    = |gnt;
        wr_addr  = gnt[ReqLoc] ? loc_wr_addr : spi_wr_addr;
        wr_data  = gnt[ReqLoc] ? loc_wr_data : spi_wr_data;
        in_range = addr_in_range(wr_addr, NUM_REGS);
        duty_wr  = wr_en && in_range && (wr_addr == ADDR_DUTY);
    end

    assign wrap = &cnt_q;

    // Next state for counter, duty double buffer and sticky error.
    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        duty_d   = duty_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        // Commit uses the shadow as it stood before this edge.
        if (wrap && pend_q) begin
            duty_d = shadow_q;
            pend_d = 1'b0;
        end
        // A write on the wrap edge lands in the shadow for the following period.
        if (duty_wr) begin
            shadow_d = wr_data;
            pend_d   = 1'b1;
        end
        err_d = err_q | (wr_en & ~in_range);
    end

    // Directly-active configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_lo_q <= '0;
            out_en_hi_q <= '0;
            pwm_en_lo_q <= '0;
            pwm_en_hi_q <= '0;
        end else if (wr_en && in_range) begin
            case (wr_addr)
                ADDR_OUT_EN_LO: out_en_lo_q <= wr_data;
                ADDR_OUT_EN_HI: out_en_hi_q <= wr_data;
                ADDR_PWM_EN_LO: pwm_en_lo_q <= wr_data;
                ADDR_PWM_EN_HI: pwm_en_hi_q <= wr_data;
                default: ;
            endcase
        end
    end

    // Period counter, duty buffers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign out_en_lo      = out_en_lo_q;
    assign out_en_hi      = out_en_hi_q;
    assign pwm_en_lo      = pwm_en_lo_q;
    assign pwm_en_hi      = pwm_en_hi_q;
    assign duty           = duty_q;
    assign pwm_cnt        = cnt_q;
    assign period_start   = (cnt_q == '0);
    assign commit_pending = pend_q;
    assign err_addr       = err_q;

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// Directed self-checking bench for pwm_reg_scheduler.
module tb_pwm_reg_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_wr_valid, loc_wr_valid;
    logic [6:0] spi_wr_addr, loc_wr_addr;
    logic [7:0] spi_wr_data, loc_wr_data;
    logic       spi_wr_ready, loc_wr_ready;
    logic [7:0] out_en_lo, out_en_hi, pwm_en_lo, pwm_en_hi, duty, pwm_cnt;
    logic       period_start, commit_pending, err_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_reg_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .spi_wr_valid   (spi_wr_valid),
        .spi_wr_addr    (spi_wr_addr),
        .spi_wr_data    (spi_wr_data),
        .spi_wr_ready   (spi_wr_ready),
        .loc_wr_valid   (loc_wr_valid),
        .loc_wr_addr    (loc_wr_addr),
        .loc_wr_data    (loc_wr_data),
        .loc_wr_ready   (loc_wr_ready),
        .out_en_lo      (out_en_lo),
        .out_en_hi      (out_en_hi),
        .pwm_en_lo      (pwm_en_lo),
        .pwm_en_hi      (pwm_en_hi),
        .duty           (duty),
        .pwm_cnt        (pwm_cnt),
        .period_start   (period_start),
        .commit_pending (commit_pending),
        .err_addr       (err_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        spi_wr_valid = 1'b0;
        loc_wr_valid = 1'b0;
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        int n = 0;
        while (pwm_cnt !== v && n < 600) begin
            step();
            n++;
        end
        check("wait_cnt", {24'd0, pwm_cnt}, {24'd0, v});
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        spi_wr_valid = 1'b1;
        spi_wr_addr  = a;
        spi_wr_data  = d;
        #1;
        check("spi_ready", {31'd0, spi_wr_ready}, 32'd1);
        step();
        spi_wr_valid = 1'b0;
    endtask

    logic [7:0] spi_tbl [4];
    logic [7:0] loc_tbl [4];
    logic [1:0] gnt_exp [4];

    initial begin
        spi_tbl = '{8'h10, 8'h11, 8'h30, 8'h31};
        loc_tbl = '{8'h20, 8'h20, 8'h21, 8'h40};
        gnt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset with a write offered: it must be refused and dropped.
        rst = 1'b1;
        spi_wr_valid = 1'b1; spi_wr_addr = 7'd0; spi_wr_data = 8'h11;
        loc_wr_valid = 1'b1; loc_wr_addr = 7'd1; loc_wr_data = 8'h22;
        #2;
        check("ready_in_rst", {30'd0, loc_wr_ready, spi_wr_ready}, 32'd0);
        step();
        step();
        check("ready_in_rst2", {30'd0, loc_wr_ready, spi_wr_ready}, 32'd0);
        idle();
        rst = 1'b0;
        check("rst_regs", {out_en_lo, out_en_hi, pwm_en_lo, pwm_en_hi}, 32'd0);
        check("rst_cnt", {24'd0, pwm_cnt}, 32'd0);
        check("rst_flags", {29'd0, period_start, commit_pending, err_addr}, 32'b100);
        check("rst_duty", {24'd0, duty}, 32'd0);

        // Contention: grants alternate starting with SPI.
        for (int i = 0; i < 4; i++) begin
            spi_wr_valid = 1'b1; spi_wr_addr = 7'd0; spi_wr_data = spi_tbl[i];
            loc_wr_valid = 1'b1; loc_wr_addr = 7'd1; loc_wr_data = loc_tbl[i];
            #1;
            check($sformatf("rr_gnt%0d", i), {30'd0, loc_wr_ready, spi_wr_ready},
                  {30'd0, gnt_exp[i]});
            step();
        end
        idle();
        check("rr_out_en_lo", {24'd0, out_en_lo}, 32'h30);
        check("rr_out_en_hi", {24'd0, out_en_hi}, 32'h40);

        // Single-requester writes.
        spi_write(7'd2, 8'hA5);
        check("spi_pwm_en_lo", {24'd0, pwm_en_lo}, 32'hA5);
        loc_wr_valid = 1'b1; loc_wr_addr = 7'd3; loc_wr_data = 8'h5A;
        #1;
        check("loc_only_gnt", {30'd0, loc_wr_ready, spi_wr_ready}, 32'b10);
        step();
        idle();
        check("loc_pwm_en_hi", {24'd0, pwm_en_hi}, 32'h5A);

        // Out-of-range address: accepted, flagged, no register change.
        spi_write(7'd7, 8'hFF);
        check("err_set", {31'd0, err_addr}, 32'd1);
        check("err_regs", {out_en_lo, out_en_hi, pwm_en_lo, pwm_en_hi}, 32'h3040A55A);
        check("err_duty", {23'd0, commit_pending, duty}, 32'd0);

        // Duty write mid-period commits only at the wrap.
        wait_cnt(8'd10);
        spi_write(7'd4, 8'h40);
        check("duty_pend", {23'd0, commit_pending, duty}, 32'h100);
        wait_cnt(8'd255);
        check("duty_pre_wrap", {23'd0, commit_pending, duty}, 32'h100);
        step();
        check("duty_commit", {22'd0, period_start, commit_pending, duty}, 32'h240);

        // Two writes in one period: only the last one commits.
        wait_cnt(8'd50);
        spi_write(7'd4, 8'h11);
        spi_write(7'd4, 8'h22);
        wait_cnt(8'd0);
        check("last_wins", {23'd0, commit_pending, duty}, 32'h022);

        // Write on the wrap edge: old shadow commits, new one stays pending.
        wait_cnt(8'd100);
        spi_write(7'd4, 8'h40);
        wait_cnt(8'd255);
        loc_wr_valid = 1'b1; loc_wr_addr = 7'd4; loc_wr_data = 8'h80;
        #1;
        check("wrap_wr_gnt", {31'd0, loc_wr_ready}, 32'd1);
        step();
        idle();
        check("wrap_wr_commit", {23'd0, commit_pending, duty}, 32'h140);
        wait_cnt(8'd128);
        check("wrap_wr_hold", {23'd0, commit_pending, duty}, 32'h140);
        wait_cnt(8'd0);
        check("wrap_wr_next", {23'd0, commit_pending, duty}, 32'h080);

        // Reset mid-period with a commit pending and pointer favouring LOC.
        wait_cnt(8'd77);
        spi_write(7'd4, 8'h99);
        rst = 1'b1;
        step();
        check("mid_rst_regs", {out_en_lo, out_en_hi, pwm_en_lo, pwm_en_hi}, 32'd0);
        check("mid_rst_state", {pwm_cnt, duty, 13'd0, period_start, commit_pending, err_addr},
              32'h00000004);
        rst = 1'b0;
        spi_wr_valid = 1'b1; spi_wr_addr = 7'd0; spi_wr_data = 8'h01;
        loc_wr_valid = 1'b1; loc_wr_addr = 7'd1; loc_wr_data = 8'h02;
        #1;
        check("mid_rst_ptr", {30'd0, loc_wr_ready, spi_wr_ready}, 32'b01);
        step();
        idle();
        check("post_rst_wr", {16'd0, out_en_lo, out_en_hi}, 32'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
